// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
// add_sub_pkg : flag bit layout and operation encoding for pipelined_add_sub
// Revision    : 1.0
// ============================================================================
package add_sub_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/add_sub_segment.sv
`default_nettype none
// ============================================================================
// add_segment : SEG_W-bit ripple adder built from full_adder cells; exposes the
//               carry into its MSB so the final stage can derive overflow.
// Revision    : 1.0
// ============================================================================
module add_segment #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [SEG_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout    = carry[SEG_W];
  assign msb_cin = carry[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : single-bit full adder cell used to build the ripple segments
// Revision   : 1.0
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// pipelined_add_sub : WIDTH-bit add/subtract, carry chain split over STAGES
//                     registered segments, valid/ready with global stall, NZCV.
//                     Optional clamping on signed overflow: ADD_SUB_SATURATE_EN.
// Revision          : 1.0
// ============================================================================
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADD_SUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SEG_W = WIDTH / STAGES;

  logic advance;
  op_t  op;

  // Stage-k inputs: index 0 comes from the ports, index k+1 from register k.
  logic             s_vld [0:STAGES-1];
  logic [WIDTH-1:0] s_a   [0:STAGES-1];
  logic [WIDTH-1:0] s_b   [0:STAGES-1];
  logic [WIDTH-1:0] s_res [0:STAGES-1];
  logic             s_cy  [0:STAGES-1];
  logic             s_sat [0:STAGES-1];

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign op       = sub ? OP_SUB : OP_ADD;

  assign s_vld[0] = in_valid;
  assign s_a[0]   = a;
  assign s_b[0]   = (op == OP_SUB) ? ~b : b;
  assign s_res[0] = '0;
  assign s_cy[0]  = (op == OP_SUB);
`ifdef ADD_SUB_SATURATE_EN
  assign s_sat[0] = sat;
`else
  assign s_sat[0] = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic             seg_msb_cin;
    logic [WIDTH-1:0] res_next;

    add_segment #(.SEG_W(SEG_W)) u_seg (
      .a       (s_a[k][k*SEG_W +: SEG_W]),
      .b       (s_b[k][k*SEG_W +: SEG_W]),
      .cin     (s_cy[k]),
      .sum     (seg_sum),
      .cout    (seg_cout),
      .msb_cin (seg_msb_cin)
    );

    always_comb begin
      res_next                   = s_res[k];
      res_next[k*SEG_W +: SEG_W] = seg_sum;
    end

    if (k == STAGES - 1) begin : g_last
      logic             n_f;
      logic             z_f;
      logic             c_f;
      logic             v_f;
      logic [WIDTH-1:0] res_fin;
      flags_t           flags_next;
      logic             unused_last;

      // N, C and V describe the raw sum; only Z follows a clamped result.
      always_comb begin
        c_f     = seg_cout;
        v_f     = seg_msb_cin ^ seg_cout;
        n_f     = res_next[WIDTH-1];
        res_fin = res_next;
        if (s_sat[k] && v_f) begin
          res_fin = n_f ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
        z_f                = (res_fin == '0);
        flags_next         = '0;
        flags_next[FLAG_N] = n_f;
        flags_next[FLAG_Z] = z_f;
        flags_next[FLAG_C] = c_f;
        flags_next[FLAG_V] = v_f;
      end

      // Operand slices below the final segment are already consumed upstream.
      assign unused_last = ^{s_a[k], s_b[k]};

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          result    <= '0;
          flags     <= '0;
        end else if (advance) begin
          out_valid <= s_vld[k];
          result    <= res_fin;
          flags     <= flags_next;
        end
      end
    end else begin : g_mid
      logic             r_vld;
      logic             r_cy;
      logic             r_sat;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_res;
      logic             unused_mid;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_sat <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_res <= '0;
        end else if (advance) begin
          r_vld <= s_vld[k];
          r_cy  <= seg_cout;
          r_sat <= s_sat[k];
          r_a   <= s_a[k];
          r_b   <= s_b[k];
          r_res <= res_next;
        end
      end

      assign s_vld[k+1] = r_vld;
      assign s_cy[k+1]  = r_cy;
      assign s_sat[k+1] = r_sat;
      assign s_a[k+1]   = r_a;
      assign s_b[k+1]   = r_b;
      assign s_res[k+1] = r_res;
      assign unused_mid = seg_msb_cin;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// tb_pipelined_add_sub : directed vector table, hand sequences for stall, bubbles
// and reset, plus randomized traffic scored against an arithmetic reference model.
module tb_pipelined_add_sub;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  int total = 0;
  int bad   = 0;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
`ifdef ADD_SUB_SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct packed {
    logic [63:0] r;
    logic [3:0]  f;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: two's-complement arithmetic on the whole word, flags from signs.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic s, input logic st);
    exp_t        e;
    logic [64:0] wide;
    logic [63:0] r;
    logic        n, z, c, v;
    if (!s) begin
      wide = {1'b0, x} + {1'b0, y};
      r    = wide[63:0];
      c    = wide[64];
      v    = (x[63] == y[63]) && (r[63] != x[63]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[63] != y[63]) && (r[63] != x[63]);
    end
    n = r[63];
    if (st && v) r = n ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
    z   = (r == 64'd0);
    e.r = r;
    e.f = {n, z, c, v};
    return e;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h0000_0000_0000_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_vector(input string tag, input vec_t v);
    int          lat;
    logic [63:0] r_act;
    logic [3:0]  f_act;
    a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    #2;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat   = -1;
    r_act = '0;
    f_act = '0;
    for (int c = 1; c <= 12; c++) begin
      #2;
      if (out_valid) begin
        lat   = c;
        r_act = result;
        f_act = flags;
      end
      step();
      if (lat >= 0) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(STAGES));
    chk({tag, "_result"}, r_act, v.r);
    chk({tag, "_flags"}, f_act, v.f);
  endtask

  task automatic backpressure();
    logic [63:0] held;
    logic [63:0] got[$];
    int          nacc;
    int          stall;
    nacc  = 0;
    stall = 0;
    held  = '0;
    for (int cyc = 0; cyc < 80 && got.size() < 8; cyc++) begin
      in_valid  = (nacc < 8);
      a         = 64'(nacc);
      b         = 64'd100;
      sub       = 1'b0;
      out_ready = !(got.size() == 1 && stall < 6);
      #2;
      if (!out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        if (stall == 0) held = result;
        else chk("bp_result_hold", result, held);
        stall++;
      end
      if (out_valid && out_ready) got.push_back(result);
      if (in_valid && in_ready) nacc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd8);
    for (int j = 0; j < got.size(); j++) chk("bp_order", got[j], 64'(100 + j));
  endtask

  task automatic bubbles();
    logic        pat [4];
    logic        seen [12];
    logic [63:0] dq[$];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4) ? pat[c] : 1'b0;
      a = 64'(c * 10); b = 64'd1; sub = 1'b0;
      #2;
      seen[c] = out_valid;
      if (out_valid) begin
        if (dq.size() == 0) chk("bubble_spurious", 1, 0);
        else chk("bubble_data", result, dq.pop_front());
      end
      if (in_valid && in_ready) dq.push_back(64'(c * 10 + 1));
      step();
    end
    for (int c = 0; c < 12; c++)
      chk("bubble_valid", seen[c], (c >= STAGES && c < STAGES + 4) ? pat[c-STAGES] : 1'b0);
  endtask

  task automatic reset_midflight();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      a = 64'(c + 1); b = 64'd2; sub = 1'b0; in_valid = 1'b1;
      #2;
      chk("rst_fill_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    #2;
    chk("rst_pre_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("rst_no_stale", out_valid, 0);
      step();
    end
  endtask

  task automatic random_run(input int n);
    exp_t exp_q[$];
    exp_t e;
    bit   pend;
    pend = 1'b0;
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      if (!pend) begin
        if (cyc < n && $urandom_range(0, 9) < 7) begin
          a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_SATURATE_EN
          sat = 1'($urandom_range(0, 1));
`endif
          in_valid = 1'b1;
          pend     = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (cyc >= n) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_result", result, e.r);
          chk("rnd_flags", flags, e.f);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, sat));
        pend = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    chk("rnd_drained", 64'(exp_q.size()), 0);
    sat = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    vecs[0] = '{64'd5, 64'd7, 1'b0, 64'd12, 4'b0000};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110};
    vecs[3] = '{64'd3, 64'd3, 1'b1, 64'd0, 4'b0110};
    vecs[4] = '{64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[6] = '{64'd0, 64'd0, 1'b1, 64'd0, 4'b0110};
    vecs[7] = '{64'h0000_0001_0000_0000, 64'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 4'b0010};
    vecs[8] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 4'b0000};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};

    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    reset_n = 1'b1;
    step();
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vector($sformatf("vec%0d", i), vecs[i]);

`ifdef ADD_SUB_SATURATE_EN
    sat = 1'b1;
    run_vector("sat_pos", '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                            64'h7FFF_FFFF_FFFF_FFFF, 4'b1001});
    run_vector("sat_neg", '{64'h8000_0000_0000_0000, 64'd1, 1'b1,
                            64'h8000_0000_0000_0000, 4'b0011});
    sat = 1'b0;
`endif

    backpressure();
    bubbles();
    reset_midflight();
    random_run(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
